serial_word_adder: RTL and testbench



---
 rtl/serial_word_adder_pkg.sv | 27 ++
 rtl/serial_word_adder_add8_slice.sv | 22 ++
 rtl/serial_word_adder.sv | 135 +++++++++++++
 tb/tb_serial_word_adder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_word_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_adder_pkg
//  Description : Shared types and constants for the serial word adder.
//                Provides the FSM state type, the adder slice width and a
//                helper that sizes the slice index register.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_word_adder_pkg;

    // Width of one adder slice in bits
    localparam int SLICE_W = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice index; never below one bit
    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage : serial_word_adder_pkg
`default_nettype wire

// File: rtl/serial_word_adder_add8_slice.sv
`default_nettype none
// ============================================================================
//  Module      : add8_slice
//  Description : Combinational 8-bit adder slice with carry in and carry out.
//                Time-multiplexed by the serial word adder sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module add8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    // Nine-bit sum keeps the carry out of bit 7
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    end

endmodule : add8_slice
`default_nettype wire

// File: rtl/serial_word_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_adder
//  Description : Multi-cycle (8*WORDS)-bit adder. Operands are registered on
//                an input handshake, then summed one 8-bit slice per clock
//                through a single add8_slice with a registered carry chain.
//                The result is held until the output handshake completes.
//  Options     : define SIGNED_OVF_EN to add the registered signed overflow
//                output ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] A,
    input  logic [SLICE_W*WORDS-1:0] B,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     cout
`ifdef SIGNED_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int W  = SLICE_W * WORDS;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [7:0]      slice_s;
    logic            slice_co;
    logic            accept;
    logic            last_slice;

    assign accept     = in_valid && (state == IDLE);
    assign last_slice = (state == RUN) && (idx == LAST_IDX);

    add8_slice u_slice (
        .a  (a_q[SLICE_W*idx +: SLICE_W]),
        .b  (b_q[SLICE_W*idx +: SLICE_W]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, slice sequencing and result accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[SLICE_W*idx +: SLICE_W] <= slice_s;
            carry                       <= slice_co;
            if (last_slice) begin
                cout <= slice_co;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef SIGNED_OVF_EN
    // Signed overflow from the latched operand signs and the final MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_slice) begin
            ovf <= (a_q[W-1] == b_q[W-1]) && (slice_s[7] != a_q[W-1]);
        end
    end
`endif

endmodule : serial_word_adder
`default_nettype wire

// File: tb/tb_serial_word_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_adder
//  Description : Directed self-checking bench for serial_word_adder, WORDS=4.
//                Checks ovf as well when SIGNED_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_adder;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SIGNED_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_word_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef SIGNED_OVF_EN
        check({tag, ".ovf"}, W'(ovf), W'(exp));
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    // Wait (bounded) for out_valid
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, ".valid_seen"}, W'(out_valid), W'(1));
    endtask

    // Full transaction with exact latency and result checks, then consume
    task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] es, input logic ec,
                          input logic eo);
        A = a; B = b; cin = ci; in_valid = 1'b1;
        check({tag, ".in_ready"}, W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        A = ~a; B = ~b; cin = ~ci;
        for (int i = 0; i < WORDS - 1; i++) begin
            check({tag, ".busy"}, {W'(out_valid), W'(in_ready)}, '0);
            step();
        end
        check({tag, ".not_early"}, W'(out_valid), W'(0));
        step();
        check({tag, ".latency"}, W'(out_valid), W'(1));
        check({tag, ".sum"}, sum, es);
        check({tag, ".cout"}, W'(cout), W'(ec));
        check_ovf(tag, eo);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".idle"}, {W'(out_valid), W'(in_ready)}, W'(1));
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("reset.in_ready", W'(in_ready), W'(1));
        check("reset.out_valid", W'(out_valid), W'(0));
        check("reset.sum", sum, '0);
        check("reset.cout", W'(cout), W'(0));
        check_ovf("reset", 1'b0);
        rst_n = 1'b1;
        step();

        // Carry across slice 0 -> 1
        do_add("c1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        // Full wrap, and cin alone
        do_add("c2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_add("c2b", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);

        // Backpressure after a case-1 add
        A = 32'h0000_00FF; B = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid("c3");
        for (int i = 0; i < 5; i++) begin
            check("c3.hold_valid", W'(out_valid), W'(1));
            check("c3.hold_ready", W'(in_ready), W'(0));
            check("c3.hold_sum", sum, 32'h0000_0100);
            check("c3.hold_cout", W'(cout), W'(0));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("c3.release_ready", W'(in_ready), W'(1));
        check("c3.release_valid", W'(out_valid), W'(0));
        check("c3.idle_sum_held", sum, 32'h0000_0100);

        // Back-to-back with in_valid held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 32'h1234_5678; B = 32'h1111_1111; cin = 1'b0;
        step();
        A = 32'h8000_0000; B = 32'h8000_0000;
        wait_valid("c4a");
        check("c4a.sum", sum, 32'h2345_6789);
        check("c4a.cout", W'(cout), W'(0));
        check_ovf("c4a", 1'b0);
        step();
        check("c4.no_same_cycle_accept", W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        wait_valid("c4b");
        check("c4b.sum", sum, 32'h0000_0000);
        check("c4b.cout", W'(cout), W'(1));
        check_ovf("c4b", 1'b1);
        step();
        out_ready = 1'b0;
        check("c4b.idle", W'(in_ready), W'(1));

        // Reset during the second RUN cycle
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("c5.out_valid", W'(out_valid), W'(0));
        check("c5.in_ready", W'(in_ready), W'(1));
        check("c5.sum", sum, '0);
        check("c5.cout", W'(cout), W'(0));
        do_add("c5.after", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

        // Signed overflow boundaries
        do_add("c6a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_add("c6b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_word_adder
`default_nettype wire
